// File: rtl/pcpi_img_reduce.sv
// rtl/pcpi_img_reduce.sv - PCPI coprocessor reducing an in-memory word-per-pixel buffer to a sum (or max with PCPI_IMG_MAX_EN)
module pcpi_img_reduce #(
    parameter int DATA_BITS   = 8,
    parameter int ADDR_STRIDE = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE,
        S_COOL
    } state_t;

    localparam logic [63:0] PIX_MASK_W = (64'd1 << DATA_BITS) - 64'd1;
    localparam logic [31:0] PIX_MASK   = PIX_MASK_W[31:0];
    localparam logic [31:0] STRIDE     = 32'(ADDR_STRIDE);

    state_t      state;
    state_t      state_nx;
    logic [31:0] cur_addr;
    logic [31:0] n_words;
    logic [31:0] idx;
    logic [31:0] acc;
    logic [31:0] acc_nx;
    logic [31:0] pixel;
    logic        is_custom;
    logic        match_sum;
    logic        match_max;
    logic        match;
    logic        last_word;
    logic        unused_ok;

    assign is_custom = (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[31:25] == 7'b0000001);
    assign match_sum = is_custom && (pcpi_insn[14:12] == 3'b000);
`ifdef PCPI_IMG_MAX_EN
    assign match_max = is_custom && (pcpi_insn[14:12] == 3'b001);
`else
    assign match_max = 1'b0;
`endif
    assign match     = match_sum || match_max;
    assign pixel     = mem_rdata & PIX_MASK;
    assign last_word = ((idx + 32'd1) == n_words);
    assign unused_ok = ^{pcpi_insn[24:15], pcpi_insn[11:7], pcpi_rs1[1:0], mem_rdata};

    assign mem_write = 1'b0;
    assign mem_wdata = 32'd0;

`ifdef PCPI_IMG_MAX_EN
    logic is_max;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            is_max <= 1'b0;
        end else if (state == S_IDLE && pcpi_valid && match) begin
            is_max <= match_max;
        end
    end

    always_comb begin
        acc_nx = acc + pixel;
        if (is_max) begin
            acc_nx = (pixel > acc) ? pixel : acc;
        end
    end
`else
    always_comb begin
        acc_nx = acc + pixel;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cur_addr <= 32'd0;
            n_words  <= 32'd0;
            idx      <= 32'd0;
            acc      <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && pcpi_valid && match) begin
                cur_addr <= {pcpi_rs1[31:2], 2'b00};
                n_words  <= pcpi_rs2;
                idx      <= 32'd0;
                acc      <= 32'd0;
            end else if (state == S_REQ && pcpi_valid && mem_ready) begin
                cur_addr <= cur_addr + STRIDE;
                idx      <= idx + 32'd1;
                acc      <= acc_nx;
            end
        end
    end

    // An abort (pcpi_valid dropped) takes priority over a same-cycle memory response.
    always_comb begin
        state_nx   = state;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'd0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = 32'd0;
        case (state)
            S_IDLE: begin
                if (pcpi_valid && match) begin
                    state_nx = (pcpi_rs2 == 32'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem_valid = 1'b1;
                mem_addr  = cur_addr;
                pcpi_wait = 1'b1;
                if (!pcpi_valid) begin
                    state_nx = S_IDLE;
                end else if (mem_ready) begin
                    state_nx = last_word ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                pcpi_wait = 1'b1;
                state_nx  = pcpi_valid ? S_REQ : S_IDLE;
            end
            S_DONE: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = 1'b1;
                pcpi_rd    = acc;
                state_nx   = S_COOL;
            end
            S_COOL: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pcpi_img_reduce.sv
// tb/tb_pcpi_img_reduce.sv - directed self-checking bench for pcpi_img_reduce (8-bit and 32-bit pixel instances)
module tb_pcpi_img_reduce;

    localparam logic [31:0] INSN_SUM = 32'h0200000B;
    localparam logic [31:0] INSN_MAX = 32'h0200100B;
    localparam logic [31:0] INSN_MUL = 32'h02000033;
    localparam logic [31:0] INSN_F3_2 = 32'h0200200B;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = 32'd0;
    logic [31:0] pcpi_rs1 = 32'd0;
    logic [31:0] pcpi_rs2 = 32'd0;

    logic        wr8, wait8, ready8, mv8, mw8, mr8;
    logic [31:0] rd8, ma8, mwd8, mrd8;
    logic        wr32, wait32, ready32, mv32, mw32, mr32;
    logic [31:0] rd32, ma32, mwd32, mrd32;

    logic [31:0] mem [0:63];
    int          lat = 1;
    int          cnt8 = 0;
    int          cnt32 = 0;

    int          n_checks = 0;
    int          n_pass = 0;

    int          rdy_cyc;
    int          wait_first;
    logic [31:0] rd_v;
    logic [31:0] rd32_v;
    logic        wr_v;
    logic [63:0] vlog;
    logic [31:0] acc_addr [$];
    bit          addr_unstable;
    bit          any_wait;
    bit          any_ready;
    bit          any_mv;

    always #5 clk = ~clk;

    pcpi_img_reduce #(.DATA_BITS(8), .ADDR_STRIDE(4)) dut (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr8), .pcpi_rd(rd8),
        .pcpi_wait(wait8), .pcpi_ready(ready8), .mem_valid(mv8), .mem_ready(mr8),
        .mem_write(mw8), .mem_addr(ma8), .mem_wdata(mwd8), .mem_rdata(mrd8)
    );

    pcpi_img_reduce #(.DATA_BITS(32), .ADDR_STRIDE(4)) dut32 (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr32), .pcpi_rd(rd32),
        .pcpi_wait(wait32), .pcpi_ready(ready32), .mem_valid(mv32), .mem_ready(mr32),
        .mem_write(mw32), .mem_addr(ma32), .mem_wdata(mwd32), .mem_rdata(mrd32)
    );

    assign mrd8  = mem[ma8[7:2]];
    assign mrd32 = mem[ma32[7:2]];

    // Responders ignore resetn on purpose so a stale ready can outlive a DUT reset.
    always @(posedge clk) begin
        if (lat == 1) begin
            mr8  <= mv8;
            cnt8 <= 0;
        end else if (mr8) begin
            mr8  <= 1'b0;
            cnt8 <= 0;
        end else if (mv8) begin
            if (cnt8 + 1 >= lat) mr8 <= 1'b1;
            cnt8 <= cnt8 + 1;
        end else begin
            cnt8 <= 0;
        end
    end

    always @(posedge clk) begin
        if (lat == 1) begin
            mr32  <= mv32;
            cnt32 <= 0;
        end else if (mr32) begin
            mr32  <= 1'b0;
            cnt32 <= 0;
        end else if (mv32) begin
            if (cnt32 + 1 >= lat) mr32 <= 1'b1;
            cnt32 <= cnt32 + 1;
        end else begin
            cnt32 <= 0;
        end
    end

    // Drives one request; observation index c is the cycle whose closing edge is c after the sampling edge.
    task automatic run_op(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                          input int max_cyc);
        logic [31:0] prev_addr;
        logic [31:0] prev_addr32;
        logic        prev_v;
        logic        prev_v32;
        rdy_cyc = -1; wait_first = -1; rd_v = 32'd0; rd32_v = 32'd0; wr_v = 1'b0;
        vlog = 64'd0; acc_addr.delete();
        addr_unstable = 0; any_wait = 0; any_ready = 0; any_mv = 0;
        prev_v = 1'b0; prev_v32 = 1'b0; prev_addr = 32'd0; prev_addr32 = 32'd0;
        pcpi_insn = insn; pcpi_rs1 = rs1; pcpi_rs2 = rs2; pcpi_valid = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (c < 64) vlog[c] = mv8;
            if (wait8 && wait_first < 0) wait_first = c;
            any_wait  = any_wait | wait8;
            any_ready = any_ready | ready8;
            any_mv    = any_mv | mv8;
            if (mv8 && prev_v && ma8 !== prev_addr) addr_unstable = 1;
            if (mv32 && prev_v32 && ma32 !== prev_addr32) addr_unstable = 1;
            if (mv8 && mr8) acc_addr.push_back(ma8);
            prev_v = mv8; prev_addr = ma8; prev_v32 = mv32; prev_addr32 = ma32;
            if (ready32) rd32_v = rd32;
            if (ready8) begin
                rdy_cyc = c; rd_v = rd8; wr_v = wr8;
                break;
            end
        end
        pcpi_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({wr8, ready8, wait8, mv8, mw8} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {wr8, ready8, wait8, mv8, mw8});
        else n_pass++;
        n_checks++;
        if ({rd8, ma8, mwd8} !== 96'd0)
            $display("FAIL reset_buses: got rd=%h addr=%h wdata=%h expected 0", rd8, ma8, mwd8);
        else n_pass++;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sum();
        logic [63:0] exp_v;
        mem[0] = 32'h10; mem[1] = 32'hFF; mem[2] = 32'hABCDEF01; mem[3] = 32'h07;
        run_op(INSN_SUM, 32'h00010000, 32'd4, 40);
        n_checks++;
        if (rdy_cyc !== 12) $display("FAIL sum_ready_cycle: got %0d expected 12", rdy_cyc);
        else n_pass++;
        n_checks++;
        if (rd_v !== 32'h117) $display("FAIL sum_rd: got %h expected 00000117", rd_v);
        else n_pass++;
        n_checks++;
        if (wr_v !== 1'b1) $display("FAIL sum_wr: got %b expected 1", wr_v);
        else n_pass++;
        n_checks++;
        if (wait_first !== 1) $display("FAIL sum_wait_rise: got %0d expected 1", wait_first);
        else n_pass++;
        n_checks++;
        if (acc_addr.size() !== 4) $display("FAIL sum_addr_count: got %0d expected 4", acc_addr.size());
        else n_pass++;
        for (int i = 0; i < acc_addr.size() && i < 4; i++) begin
            n_checks++;
            if (acc_addr[i] !== 32'h00010000 + 32'(4 * i))
                $display("FAIL sum_addr%0d: got %h expected %h", i, acc_addr[i], 32'h00010000 + 32'(4 * i));
            else n_pass++;
        end
        exp_v = 64'd0;
        for (int c = 1; c <= 11; c++) exp_v[c] = (c % 3) != 0;
        n_checks++;
        if (vlog[12:1] !== exp_v[12:1])
            $display("FAIL sum_mem_valid_pattern: got %b expected %b", vlog[12:1], exp_v[12:1]);
        else n_pass++;
    endtask

    task automatic test_n_zero();
        run_op(INSN_SUM, 32'h00010000, 32'd0, 10);
        n_checks++;
        if (rdy_cyc !== 1) $display("FAIL n0_ready_cycle: got %0d expected 1", rdy_cyc);
        else n_pass++;
        n_checks++;
        if (rd_v !== 32'd0) $display("FAIL n0_rd: got %h expected 0", rd_v);
        else n_pass++;
        n_checks++;
        if (any_mv !== 1'b0) $display("FAIL n0_mem_valid: got %b expected 0", any_mv);
        else n_pass++;
    endtask

    task automatic test_max();
        mem[8] = 32'h03; mem[9] = 32'h1FE; mem[10] = 32'h80;
`ifdef PCPI_IMG_MAX_EN
        run_op(INSN_MAX, 32'h00010020, 32'd3, 30);
        n_checks++;
        if (rdy_cyc !== 9) $display("FAIL max_ready_cycle: got %0d expected 9", rdy_cyc);
        else n_pass++;
        n_checks++;
        if (rd_v !== 32'hFE) $display("FAIL max_rd: got %h expected 000000fe", rd_v);
        else n_pass++;
`else
        run_op(INSN_MAX, 32'h00010020, 32'd3, 20);
        n_checks++;
        if (any_wait !== 1'b0) $display("FAIL max_off_wait: got %b expected 0", any_wait);
        else n_pass++;
        n_checks++;
        if (any_ready !== 1'b0) $display("FAIL max_off_ready: got %b expected 0", any_ready);
        else n_pass++;
`endif
    endtask

    task automatic test_nonmatch();
        run_op(INSN_MUL, 32'h00010000, 32'd4, 20);
        n_checks++;
        if ({any_wait, any_ready, any_mv} !== 3'b000)
            $display("FAIL mul_quiet: got wait/ready/mvalid=%b expected 000", {any_wait, any_ready, any_mv});
        else n_pass++;
        run_op(INSN_F3_2, 32'h00010000, 32'd4, 20);
        n_checks++;
        if ({any_wait, any_ready, any_mv} !== 3'b000)
            $display("FAIL funct3_2_quiet: got wait/ready/mvalid=%b expected 000", {any_wait, any_ready, any_mv});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pcpi_insn = INSN_SUM; pcpi_rs1 = 32'h00010000; pcpi_rs2 = 32'd8; pcpi_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (mv8 !== 1'b1) $display("FAIL midreset_busy: got mem_valid=%b expected 1", mv8);
        else n_pass++;
        resetn = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({wr8, ready8, wait8, mv8, mw8, rd8, ma8, mwd8} !== 101'd0)
            $display("FAIL midreset_outputs: got wait=%b mvalid=%b addr=%h rd=%h expected 0", wait8, mv8, ma8, rd8);
        else n_pass++;
        resetn = 1'b1;
        mem[16] = 32'd5; mem[17] = 32'd6;
        run_op(INSN_SUM, 32'h00010040, 32'd2, 20);
        n_checks++;
        if (rd_v !== 32'd11) $display("FAIL midreset_rd: got %0d expected 11", rd_v);
        else n_pass++;
        n_checks++;
        if (rdy_cyc !== 6) $display("FAIL midreset_ready_cycle: got %0d expected 6", rdy_cyc);
        else n_pass++;
    endtask

    task automatic test_slow();
        lat = 5;
        mem[32] = 32'hFFFFFFFF; mem[33] = 32'h2;
        run_op(INSN_SUM, 32'h00010082, 32'd2, 40);
        lat = 1;
        n_checks++;
        if (rd32_v !== 32'h1) $display("FAIL slow_rd32: got %h expected 00000001", rd32_v);
        else n_pass++;
        n_checks++;
        if (rd_v !== 32'h101) $display("FAIL slow_rd8: got %h expected 00000101", rd_v);
        else n_pass++;
        n_checks++;
        if (addr_unstable !== 1'b0) $display("FAIL slow_addr_stable: got %b expected 0", addr_unstable);
        else n_pass++;
        n_checks++;
        if (rdy_cyc !== 14) $display("FAIL slow_ready_cycle: got %0d expected 14", rdy_cyc);
        else n_pass++;
        n_checks++;
        if (acc_addr.size() !== 2 || acc_addr[0] !== 32'h00010080 || acc_addr[1] !== 32'h00010084)
            $display("FAIL slow_addrs: got %0d accepts expected 2 at 00010080,00010084", acc_addr.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        test_reset();
        test_sum();
        test_n_zero();
        test_max();
        test_nonmatch();
        test_reset_mid();
        test_slow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
